// File: rtl/eth_rx_event_irq.sv
// Per-type receive event counters with a coalescing interrupt.
// Register map is word-addressed; readback is combinational.
module eth_rx_event_irq #(
  parameter int NUM_TYPES   = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 i_rx_clk,
  input  logic                 i_cmd_rst_n,
  input  logic [NUM_TYPES-1:0] i_evt,
  input  logic                 i_reg_wr,
  input  logic [3:0]           i_reg_addr,
  input  logic [31:0]          i_reg_wdata,
  output logic [31:0]          o_reg_rdata,
  output logic                 o_irq,
  output logic                 o_irq_pulse,
  output logic [7:0]           o_led
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_ASSERT
  } state_t;

  state_t               state;
  logic [NUM_TYPES-1:0] mask;
  logic [NUM_TYPES-1:0] status;
  logic [NUM_TYPES-1:0] status_nxt;
  logic [NUM_TYPES-1:0] mevt;
  logic [7:0]           thresh;
  logic [7:0]           thr_eff;
  logic [7:0]           pend;
  logic [7:0]           pend_nxt;
  logic [8:0]           pend_sum;
  logic [TW-1:0]        timer;
  logic [31:0]          total;
  logic [CNT_W-1:0]     cnt [NUM_TYPES];
  logic [3:0]           pop_all;
  logic [3:0]           pop_m;
  logic                 wr_mask;
  logic                 wr_stat;
  logic                 wr_thr;
  logic                 wr_clr;
  logic                 hit;
  logic                 mask_zero;
  logic                 irq;
  logic                 pulse;
  logic                 unused_wdata;

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  assign unused_wdata = ^i_reg_wdata[30:8];

  assign wr_mask = i_reg_wr && (i_reg_addr == 4'd0);
  assign wr_stat = i_reg_wr && (i_reg_addr == 4'd1);
  assign wr_thr  = i_reg_wr && (i_reg_addr == 4'd2);
  assign wr_clr  = i_reg_wr && (i_reg_addr == 4'd3);

  assign mevt     = i_evt & mask;
  assign pop_all  = popcnt(8'(i_evt));
  assign pop_m    = popcnt(8'(mevt));
  assign pend_sum = {1'b0, pend} + 9'(pop_m);
  assign pend_nxt = pend_sum[8] ? 8'hFF : pend_sum[7:0];
  assign thr_eff  = (thresh == 8'd0) ? 8'd1 : thresh;
  assign hit      = pend_nxt >= thr_eff;

  // New masked events win over a same-cycle W1C of the same bit.
  assign status_nxt = (status
    & ~(wr_stat ? i_reg_wdata[NUM_TYPES-1:0] : '0)) | mevt;
  assign mask_zero = wr_mask && (i_reg_wdata[NUM_TYPES-1:0] == '0);

  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) begin
      mask   <= '1;
      status <= '0;
      thresh <= 8'd1;
    end else begin
      status <= status_nxt;
      if (wr_mask) mask <= i_reg_wdata[NUM_TYPES-1:0];
      if (wr_thr) thresh <= i_reg_wdata[7:0];
    end
  end

  for (genvar k = 0; k < NUM_TYPES; k++) begin : g_cnt
    logic [CNT_W-1:0] base;
    assign base = (wr_clr && i_reg_wdata[k]) ? '0 : cnt[k];
    always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
      if (!i_cmd_rst_n) cnt[k] <= '0;
      else if (i_evt[k] && (base != '1)) cnt[k] <= base + 1'b1;
      else cnt[k] <= base;
    end
  end

  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) total <= '0;
    else if (wr_clr && i_reg_wdata[31]) total <= 32'(pop_all);
    else total <= total + 32'(pop_all);
  end

  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) begin
      state <= S_IDLE;
      pend  <= '0;
      timer <= '0;
      irq   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|mevt) begin
            pend  <= pend_nxt;
            timer <= '0;
            if (hit) begin
              state <= S_ASSERT;
              irq   <= 1'b1;
              pulse <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if ((status_nxt == '0) && mask_zero) begin
            state <= S_IDLE;
            pend  <= '0;
            timer <= '0;
          end else begin
            pend  <= pend_nxt;
            timer <= timer + 1'b1;
            if (hit || (timer == TMAX)) begin
              state <= S_ASSERT;
              irq   <= 1'b1;
              pulse <= 1'b1;
            end
          end
        end
        S_ASSERT: begin
          if (status_nxt == '0) begin
            state <= S_IDLE;
            pend  <= '0;
            timer <= '0;
            irq   <= 1'b0;
          end else begin
            pend <= pend_nxt;
          end
        end
        default: begin
          state <= S_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_reg_rdata = '0;
    unique case (1'b1)
      i_reg_addr == 4'd0:  o_reg_rdata = 32'(mask);
      i_reg_addr == 4'd1:  o_reg_rdata = 32'(status);
      i_reg_addr == 4'd2:  o_reg_rdata = 32'(thresh);
      i_reg_addr == 4'd15: o_reg_rdata = total;
      default: begin
        for (int k = 0; k < NUM_TYPES; k++)
          if (i_reg_addr == 4'(k + 4)) o_reg_rdata = 32'(cnt[k]);
      end
    endcase
  end

  assign o_irq       = irq;
  assign o_irq_pulse = pulse;
  assign o_led       = total[7:0];

endmodule

// File: doc/eth_rx_event_irq.md
ETH_RX_EVENT_IRQ -- requirements
Module: eth_rx_event_irq

Interface
REQ-001 Parameter NUM_TYPES, default 4, number of independent packet-type event channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-type packet counter (8..32).
REQ-003 Parameter TIMEOUT_CYC, default 1024, coalescing timeout in i_rx_clk cycles (>=2).
REQ-004 i_rx_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_cmd_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_evt  input  NUM_TYPES  per-type receive-event strobes, one cycle each; several bits may be high together.
REQ-007 i_reg_wr  input  1  register write strobe, already synchronous to i_rx_clk.
REQ-008 i_reg_addr  input  4  register address.
REQ-009 i_reg_wdata  input  32  register write data.
REQ-010 o_reg_rdata  output  32  combinational readback of register at i_reg_addr.
REQ-011 o_irq  output  1  level interrupt request.
REQ-012 o_irq_pulse  output  1  one-cycle pulse on each o_irq rising edge.
REQ-013 o_led  output  8  low 8 bits of total event counter.

Function
REQ-014 Register map: 0 MASK[NUM_TYPES-1:0] RW; 1 STATUS[NUM_TYPES-1:0] write-1-to-clear; 2 THRESH[7:0] RW; 3 CLEAR write-only, bit k clears counter k, bit 31 clears total; 4+k COUNT[k] RO, zero-extended; 15 TOTAL RO; unmapped addresses read 0, writes ignored.
REQ-015 COUNT[k] increments by 1 each cycle i_evt[k]=1, independent of MASK; saturates at all-ones, no wrap.
REQ-016 TOTAL is 32-bit, increments by popcount(i_evt) each cycle, wraps modulo 2^32.
REQ-017 CLEAR with simultaneous event on same channel: counter becomes 1 (clear then count); TOTAL likewise becomes popcount(i_evt).
REQ-018 STATUS[k] sets when i_evt[k]=1 and MASK[k]=1; set wins over simultaneous W1C of same bit.
REQ-019 PEND, 8-bit saturating, adds popcount(i_evt & MASK) per cycle; THRESH value 0 treated as 1.
REQ-020 FSM states IDLE, ACCUM, ASSERT; o_irq=1 only in ASSERT.
REQ-021 IDLE -> ACCUM when any masked event arrives; timer loads 0, PEND updated same edge.
REQ-022 ACCUM -> ASSERT when PEND >= THRESH (evaluated on updated value) or timer reaches TIMEOUT_CYC-1; timer increments each ACCUM cycle.
REQ-023 Event raising PEND to >= THRESH from IDLE goes directly IDLE -> ASSERT, one-cycle latency from i_evt to o_irq.
REQ-024 ASSERT -> IDLE when STATUS becomes all-zero after a W1C with no new masked event that cycle; PEND and timer cleared.
REQ-025 ACCUM or ASSERT with STATUS cleared to zero and MASK write making all bits zero -> IDLE, PEND cleared.
REQ-026 MASK write affects events in following cycles only; already-set STATUS bits retained.
REQ-027 o_irq_pulse = 1 for exactly the first cycle of each ASSERT entry; registered output.
REQ-028 Zero combinational path from i_evt to o_irq or o_irq_pulse.

Reset
REQ-029 On i_cmd_rst_n low: all counters, TOTAL, STATUS, PEND, timer = 0; MASK = all-ones; THRESH = 1; FSM = IDLE; o_irq=0, o_irq_pulse=0, o_led=0.
REQ-030 Reset mid-ACCUM or mid-ASSERT takes effect immediately (asynchronous); first cycle after release is IDLE with no pulse.

Verification
REQ-031 Reset release, THRESH=1, single i_evt[0] pulse -> o_irq=1 next cycle, o_irq_pulse one cycle, STATUS=0x1, COUNT[0]=1, o_led=1.
REQ-032 THRESH=4, three masked events then idle -> ASSERT exactly TIMEOUT_CYC cycles after first event; four events -> ASSERT cycle after the fourth.
REQ-033 MASK=0x2, i_evt=0xF one cycle -> all COUNT=1, TOTAL=4, STATUS=0x2, PEND=1; W1C STATUS=0x2 -> o_irq=0 next cycle.
REQ-034 W1C STATUS[1] same cycle as i_evt[1] -> STATUS[1] stays 1, o_irq stays 1, no new pulse.
REQ-035 CNT_W=8, 300 events on channel 2 -> COUNT[2]=255; CLEAR bit 2 with simultaneous event -> COUNT[2]=1.
REQ-036 Assert reset during ASSERT -> o_irq=0 immediately, all registers at REQ-029 values.
